// File: rtl/qcl_ddr_rx_align_pkg.sv
// Shared types and constants for the DDR receive word-alignment controller.
package qcl_ddr_rx_align_pkg;

    localparam int unsigned LANES    = 16;
    localparam int unsigned WORD_W   = 2 * LANES;
    localparam int unsigned RISE_LSB = 0;
    localparam int unsigned RISE_MSB = LANES - 1;
    localparam int unsigned FALL_LSB = LANES;
    localparam int unsigned FALL_MSB = WORD_W - 1;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

endpackage

// File: rtl/qcl_ddr_rx_align_ctrl_if.sv
// Receiver-side bus between the DDR rx wrapper / deframer and the alignment controller.
interface qcl_ddr_rx_align_ctrl_if;
    import qcl_ddr_rx_align_pkg::*;

    logic [WORD_W-1:0] data_par_i;
    logic              retrain_i;
    logic              err_i;
    logic              rx_reset_o;
    logic [WORD_W-1:0] data_o;
    logic              v_o;
    logic              locked_o;
    logic              fail_o;

    modport master (
        output data_par_i, retrain_i, err_i,
        input  rx_reset_o, data_o, v_o, locked_o, fail_o
    );

    modport slave (
        input  data_par_i, retrain_i, err_i,
        output rx_reset_o, data_o, v_o, locked_o, fail_o
    );

endinterface

// File: rtl/qcl_ddr_rx_phase_mux.sv
// Selects which DDR half starts a word and registers the aligned result.
module qcl_ddr_rx_phase_mux
    import qcl_ddr_rx_align_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              phase_i,
    input  logic [WORD_W-1:0] data_par_i,
    output logic [WORD_W-1:0] data_o
);

    logic [LANES-1:0]  prev_q;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] aligned_c;

    // Phase 1 pairs this cycle's rising half with the previous falling half.
    always_comb begin
        aligned_c = data_par_i;
        if (phase_i) begin
            aligned_c = {data_par_i[RISE_MSB:RISE_LSB], prev_q};
        end
    end

    // Hold last falling half and register the aligned word every cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q <= '0;
            data_q <= '0;
        end else begin
            prev_q <= data_par_i[FALL_MSB:FALL_LSB];
            data_q <= aligned_c;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/qcl_ddr_rx_align_ctrl.sv
// Link bring-up: io reset, word-phase training, lock, and error-driven retrain.
module qcl_ddr_rx_align_ctrl
    import qcl_ddr_rx_align_pkg::*;
#(
    parameter logic [31:0] train_pattern_p = 32'h5A5A_A5A5,
    parameter int unsigned rst_cycles_p    = 16,
    parameter int unsigned settle_cycles_p = 8,
    parameter int unsigned lock_count_p    = 64,
    parameter int unsigned max_slips_p     = 4,
    parameter int unsigned err_thresh_p    = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    qcl_ddr_rx_align_ctrl_if.slave bus_if
);

    localparam int unsigned CNT_MAX = (rst_cycles_p > settle_cycles_p) ? rst_cycles_p
                                                                        : settle_cycles_p;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned MATCH_W = $clog2(lock_count_p + 1);
    localparam int unsigned SLIP_W  = $clog2(max_slips_p + 1);
    localparam int unsigned ERR_W   = $clog2(err_thresh_p + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [SLIP_W-1:0]  slips_q, slips_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               phase_q, phase_d;
    logic               rx_reset_q, rx_reset_d;
    logic               locked_q, locked_d;
    logic               v_q, v_d;
    logic               fail_q, fail_d;
    logic [WORD_W-1:0]  data_w;

    qcl_ddr_rx_phase_mux u_phase_mux (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .phase_i    (phase_q),
        .data_par_i (bus_if.data_par_i),
        .data_o     (data_w)
    );

    // Next-state, counter updates and registered-output decode of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        slips_d = slips_q;
        err_d   = err_q;
        phase_d = phase_q;

        unique case (state_q)
            ST_RST: begin
                if (cnt_q == CNT_W'(rst_cycles_p - 1)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(settle_cycles_p - 1)) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                    match_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (data_w == train_pattern_p) begin
                    if (match_q == MATCH_W'(lock_count_p - 1)) begin
                        state_d = ST_LOCKED;
                        err_d   = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end else begin
                    match_d = '0;
                    // Every allowed slip already spent: give up.
                    if (slips_q == SLIP_W'(max_slips_p)) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIP;
                    end
                end
            end
            ST_SLIP: begin
                phase_d = ~phase_q;
                slips_d = slips_q + SLIP_W'(1);
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_LOCKED: begin
                if (bus_if.err_i) begin
                    if (err_q == ERR_W'(err_thresh_p - 1)) begin
                        // Retrain keeping the last good phase.
                        state_d = ST_RST;
                        cnt_d   = '0;
                        slips_d = '0;
                        err_d   = '0;
                    end else begin
                        err_d = err_q + ERR_W'(1);
                    end
                end else begin
                    err_d = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase

        if (bus_if.retrain_i) begin
            state_d = ST_RST;
            cnt_d   = '0;
            match_d = '0;
            slips_d = '0;
            err_d   = '0;
            phase_d = 1'b0;
        end

        rx_reset_d = (state_d == ST_RST);
        locked_d   = (state_d == ST_LOCKED);
        v_d        = (state_d == ST_LOCKED);
        fail_d     = (state_d == ST_FAIL);
    end

    // State, counters and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            match_q    <= '0;
            slips_q    <= '0;
            err_q      <= '0;
            phase_q    <= 1'b0;
            rx_reset_q <= 1'b1;
            locked_q   <= 1'b0;
            v_q        <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            slips_q    <= slips_d;
            err_q      <= err_d;
            phase_q    <= phase_d;
            rx_reset_q <= rx_reset_d;
            locked_q   <= locked_d;
            v_q        <= v_d;
            fail_q     <= fail_d;
        end
    end

    assign bus_if.rx_reset_o = rx_reset_q;
    assign bus_if.data_o     = data_w;
    assign bus_if.v_o        = v_q;
    assign bus_if.locked_o   = locked_q;
    assign bus_if.fail_o     = fail_q;

endmodule

// File: tb/tb_qcl_ddr_rx_align_ctrl.sv
// Directed bench for the DDR receive alignment controller with a cycle-stamped scoreboard.
module tb_qcl_ddr_rx_align_ctrl;
    import qcl_ddr_rx_align_pkg::*;

    localparam logic [31:0] PAT  = 32'h5A5A_A5A5;
    localparam logic [31:0] SWAP = 32'hA5A5_5A5A;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk_i = ~clk_i;

    qcl_ddr_rx_align_ctrl_if bus ();

    qcl_ddr_rx_align_ctrl dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus_if  (bus)
    );

    typedef struct {
        int unsigned at;
        string       name;
        logic        rr;
        logic        lk;
        logic        fl;
        logic        vv;
        logic        chk_d;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          rd_idx    = 0;
    int unsigned cyc       = 0;
    int          checks    = 0;
    int          failures  = 0;
    bit          stim_done = 1'b0;
    bit          done      = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected output snapshot for cycle 'at' (cycle = posedge count, sampled at negedge).
    task automatic expect_at(input int unsigned at, input string name,
                             input logic rr, input logic lk, input logic fl, input logic vv,
                             input logic chk_d, input logic [31:0] d);
        exp_t x;
        x.at = at; x.name = name; x.rr = rr; x.lk = lk; x.fl = fl; x.vv = vv;
        x.chk_d = chk_d; x.d = d;
        sb_q.push_back(x);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s cyc=%0d actual=%h required=%h", nm, fld, cyc, act, req);
        end
    endtask

    // Monitor: pop expectations due this cycle; every valid word must be the trained pattern.
    always @(negedge clk_i) begin
        while (rd_idx < sb_q.size() && sb_q[rd_idx].at <= cyc) begin
            e = sb_q[rd_idx];
            rd_idx++;
            if (e.at != cyc) begin
                checks++;
                failures++;
                $display("FAIL %s.stale cyc=%0d due=%0d", e.name, cyc, e.at);
            end else begin
                cmp(e.name, "rx_reset_o", 32'(bus.rx_reset_o), 32'(e.rr));
                cmp(e.name, "locked_o",   32'(bus.locked_o),   32'(e.lk));
                cmp(e.name, "fail_o",     32'(bus.fail_o),     32'(e.fl));
                cmp(e.name, "v_o",        32'(bus.v_o),        32'(e.vv));
                if (e.chk_d) cmp(e.name, "data_o", bus.data_o, e.d);
            end
        end
        if (bus.v_o === 1'b1) cmp("valid_word", "data_o", bus.data_o, PAT);
        if (stim_done && !done) begin
            done = 1'b1;
            if (rd_idx < sb_q.size()) begin
                failures++;
                $display("FAIL scoreboard.leftover actual=%0d required=0", sb_q.size() - rd_idx);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Start (re)training from a negedge via reset_i or retrain_i; returns first RST cycle.
    task automatic pulse(input bit use_reset, input logic [31:0] word, input string name,
                         output int unsigned r);
        if (use_reset) reset_i = 1'b1;
        else           bus.retrain_i = 1'b1;
        bus.data_par_i = word;
        expect_at(cyc + 1, name, 1'b1, 1'b0, 1'b0, 1'b0, use_reset, 32'h0);
        @(negedge clk_i);
        reset_i       = 1'b0;
        bus.retrain_i = 1'b0;
        r = cyc;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk_i);
    endtask

    initial begin
        int unsigned r, r2, l, m;
        logic seq [8];
        bus.data_par_i = PAT;
        bus.retrain_i  = 1'b0;
        bus.err_i      = 1'b0;
        @(negedge clk_i);

        // 1: aligned stream locks after 16 reset + 8 settle + 64 matches, no slip.
        pulse(1'b1, PAT, "t1_reset", r);
        expect_at(r + 15, "t1_rst_last",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 16, "t1_rst_rel",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 87, "t1_prelock",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 88, "t1_lock",       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 90);

        // 2: half-word offset stream needs one slip to lock.
        pulse(1'b0, SWAP, "t2_retrain", r);
        expect_at(r + 25, "t2_slip",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 97, "t2_prelock",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 98, "t2_lock",       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 100);

        // 3: garbage exhausts four slips then fails; retrain clears fail.
        pulse(1'b0, 32'h0, "t3_retrain", r);
        expect_at(r + 64, "t3_prefail",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 65, "t3_fail",       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        expect_at(r + 80, "t3_fail_hold",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        wait_until(r + 81);
        pulse(1'b0, PAT, "t3_unfail", r);

        // 4: error bursts shorter than threshold keep lock; four in a row retrain.
        expect_at(r + 88, "t4_lock",       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 90);
        l = cyc;
        seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        expect_at(l + 8, "t4_err_short",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        for (int i = 0; i < 8; i++) begin
            bus.err_i = seq[i];
            @(negedge clk_i);
        end
        m = cyc;
        expect_at(m + 3, "t4_err3",        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        expect_at(m + 4, "t4_err4",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(m + 91, "t4_prerelock",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(m + 92, "t4_relock",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        for (int i = 0; i < 4; i++) begin
            bus.err_i = 1'b1;
            @(negedge clk_i);
        end
        bus.err_i = 1'b0;
        wait_until(m + 94);

        // 5: one bad word at match 40 restarts matching through slips, then locks.
        pulse(1'b0, PAT, "t5_retrain", r);
        expect_at(r + 64, "t5_badword",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        expect_at(r + 65, "t5_slip",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 88, "t5_nolock",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 147, "t5_prelock",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r + 148, "t5_lock",      1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 63);
        bus.data_par_i = 32'h0;
        @(negedge clk_i);
        bus.data_par_i = PAT;
        wait_until(r + 150);

        // 6: retrain in RST restarts the count; reset mid-CHECK/LOCKED; err ignored in CHECK.
        pulse(1'b0, PAT, "t6_retrain", r);
        wait_until(r + 5);
        pulse(1'b0, PAT, "t6_retrain_rst", r2);
        expect_at(r2 + 14, "t6_rst_ext",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r2 + 15, "t6_rst_last",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_at(r2 + 16, "t6_rst_rel",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        wait_until(r2 + 40);
        bus.err_i = 1'b1;
        pulse(1'b1, PAT, "t6_reset_check", r);
        expect_at(r + 88, "t6_lock_err",   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        expect_at(r + 95, "t6_lock_hold",  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 87);
        bus.err_i = 1'b0;
        wait_until(r + 96);
        pulse(1'b1, PAT, "t6_reset_locked", r);
        expect_at(r + 88, "t6_relock",     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, PAT);
        wait_until(r + 90);
        pulse(1'b0, PAT, "t6_retrain_locked", r);
        wait_until(r + 20);

        stim_done = 1'b1;
    end

endmodule
